lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
- Parametrised load/store unit: the sequential successor to the core's memory-op record.
- Accepts one memory operation per handshake from the ALU stage: read/write, address, store data, funct3 opType and destination register.
- Drives a synchronous data RAM with a configurable read latency.
- Returns sign- or zero-extended load data as a one-cycle register-file write-back.

Parameters:
- XLEN, 32, data and address width; must be 32 or 64.
- RAM_DEPTH, 1024, data RAM depth in XLEN-wide words; must be a power of 2.
- MEM_LAT, 1, RAM read latency in cycles (range 1..4).
- REG_SEL_W, 5, register-select width.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  memory op offered
- req_ready  out  1  unit can accept an op
- req_read  in  1  load
- req_write  in  1  store
- req_addr  in  XLEN  byte address
- req_data  in  XLEN  store data
- req_optype  in  3  funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only)
- req_rd  in  REG_SEL_W  load destination register
- mem_en  out  1  RAM access strobe
- mem_we  out  XLEN/8  byte-lane write enables
- mem_addr  out  $clog2(RAM_DEPTH)  word address
- mem_wdata  out  XLEN  lane-aligned store data
- mem_rdata  in  XLEN  RAM read data, valid MEM_LAT cycles after mem_en
- wb_dv  out  1  write-back valid (one-cycle pulse)
- wb_addr  out  REG_SEL_W  write-back register
- wb_data  out  XLEN  extended load data
- err  out  1  one-cycle pulse on an illegal or misaligned op

Behaviour:
- Clock and reset: single clock clk; rstn is synchronous and active-low.
- Reset: all outputs are 0, including req_ready while rstn=0. req_ready=1 in the first cycle after reset is released.
- Reset mid-load: the load is abandoned; no wb_dv is produced.
- Accept: an op is accepted on a rising edge with req_valid & req_ready & (req_read | req_write).
- Accept with req_read=req_write=0: consumed as a no-op.
- All mem_* outputs are registered and held for exactly the cycle after the accept edge E; otherwise mem_en=0 and mem_we=0.
- Word address: mem_addr = req_addr[$clog2(RAM_DEPTH)+$clog2(XLEN/8)-1 : $clog2(XLEN/8)]. Upper address bits are ignored, so addresses wrap modulo RAM_DEPTH words.
- FSM states: IDLE, WAIT, WB.
  - IDLE: req_ready=1.
  - Store: stays in IDLE; mem_en=1 and mem_we set for the lane mask at E+1; throughput is one store per cycle; no write-back.
  - Load: IDLE -> WAIT; mem_en=1, mem_we=0 at E+1.
  - WAIT: req_ready=0. A counter runs MEM_LAT cycles, then mem_rdata is captured; WAIT -> WB.
  - WB: wb_dv=1 for one cycle, at edge E+MEM_LAT+1. req_ready=1 in WB, so back-to-back loads are allowed; WB -> IDLE, or WB -> WAIT if a new load is accepted.
- Store lanes: byte offset off = req_addr[$clog2(XLEN/8)-1:0].
  - B: mem_we = 1<<off, with the data byte replicated across all lanes.
  - H: mem_we = 2'b11<<off, with the data half replicated.
  - W: mem_we = 4'hF<<off.
  - D: mem_we = all ones.
- Load extraction: the lane is selected by off, then sign-extended (B, H, W) or zero-extended (BU, HU, WU) to XLEN.
- rd=0 loads: the memory access is performed, but wb_dv stays 0.
- err pulses at E+1 and the op performs no RAM access and no write-back when any of these holds:
  - req_read and req_write are both 1;
  - req_optype is reserved (111), or is D/WU with XLEN=32;
  - the access is misaligned (see Optional Feature).
- A store's err cycle behaves like a store cycle: the unit stays in IDLE and req_ready stays 1.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a misaligned access raises err and is suppressed. Misaligned means H with off[0]≠0, W with off[1:0]≠0, or D with off≠0.
- Undefined: misalignment is never flagged. The offset is aligned down to the access size (off bits below the access size forced to 0) before lane and mask generation. err covers only the other illegal cases.

Test Plan:
- Reset, then store W 0xDEADBEEF to 0x10 -> at E+1: mem_en=1, mem_we=4'hF, mem_addr=4, mem_wdata=0xDEADBEEF; req_ready stays 1.
- SB 0x5A to 0x13, then LB and LBU from 0x13 (MEM_LAT=1) -> mem_we=4'b1000; the loads write back 0x0000005A from both. Then SB 0xA5 and LB -> 0xFFFFFFA5; LBU -> 0x000000A5.
- MEM_LAT=3, LW to rd=7 from a word holding 0x80001234 -> req_ready=0 for three cycles after E; wb_dv=1 exactly at E+4 with wb_addr=7 and wb_data=0x80001234.
- Back-to-back: LW accepted in the WB cycle of the previous LW -> second wb_dv arrives MEM_LAT+1 cycles after the first; no cycle is lost.
- LSU_MISALIGN_CHECK_EN defined: LH at 0x21 -> err=1 at E+1, mem_en=0, no wb_dv. Undefined: same op reads the halfword at 0x20 and produces no err. Either build: read=write=1 -> err=1.
- Edge cases:
  - LW with rd=0 -> mem_en pulses, wb_dv stays 0.
  - Address 0x0000_1004 with RAM_DEPTH=1024 -> mem_addr=1 (wrap).
  - rstn=0 during WAIT -> no wb_dv; req_ready=1 the cycle after release.

Source files
------------

// File: rtl/lsu_unit.sv
// Load/store unit driving a synchronous data RAM with a MEM_LAT-cycle read path.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned accesses; otherwise offsets are aligned down.
module lsu_unit #(
    parameter int XLEN      = 32,
    parameter int RAM_DEPTH = 1024,
    parameter int MEM_LAT   = 1,
    parameter int REG_SEL_W = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_read,
    input  logic                         req_write,
    input  logic [XLEN-1:0]              req_addr,
    input  logic [XLEN-1:0]              req_data,
    input  logic [2:0]                   req_optype,
    input  logic [REG_SEL_W-1:0]         req_rd,
    output logic                         mem_en,
    output logic [XLEN/8-1:0]            mem_we,
    output logic [$clog2(RAM_DEPTH)-1:0] mem_addr,
    output logic [XLEN-1:0]              mem_wdata,
    input  logic [XLEN-1:0]              mem_rdata,
    output logic                         wb_dv,
    output logic [REG_SEL_W-1:0]         wb_addr,
    output logic [XLEN-1:0]              wb_data,
    output logic                         err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, WB} lsuState;

    lsuState             state;
    lsuState             stateNext;
    logic [2:0]          latCnt;
    logic [1:0]          reqSize;
    logic [OFFW-1:0]     reqOff;
    logic                reqIllegal;
    logic                accept;
    logic                loadGo;
    logic [2:0]          loadOp;
    logic [OFFW-1:0]     loadOff;
    logic [REG_SEL_W-1:0] loadRd;
    logic                unusedAddr;

    function automatic logic [OFFW-1:0] alignOff(input logic [1:0] size, input logic [OFFW-1:0] off);
        case (size)
            2'b00:   return off;
            2'b01:   return off & ~OFFW'(1);
            2'b10:   return off & ~OFFW'(3);
            default: return '0;
        endcase
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    function automatic logic isMisaligned(input logic [1:0] size, input logic [OFFW-1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [NB-1:0] laneMask(input logic [1:0] size, input logic [OFFW-1:0] off);
        case (size)
            2'b00:   return NB'(1) << off;
            2'b01:   return NB'(2'b11) << off;
            2'b10:   return NB'(4'hF) << off;
            default: return '1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] replicateData(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   return {NB{data[7:0]}};
            2'b01:   return {(NB/2){data[15:0]}};
            2'b10:   return {(XLEN/32){data[31:0]}};
            default: return data;
        endcase
    endfunction

    // Lane select by byte offset, then sign- or zero-extend (op[2] set = unsigned).
    function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] raw, input logic [2:0] op,
                                                   input logic [OFFW-1:0] off);
        logic [XLEN-1:0]    lane;
        logic signed [7:0]  sB;
        logic signed [15:0] sH;
        logic signed [31:0] sW;
        lane = raw >> {off, 3'b000};
        sB   = lane[7:0];
        sH   = lane[15:0];
        sW   = lane[31:0];
        case (op[1:0])
            2'b00:   return op[2] ? XLEN'(lane[7:0])  : XLEN'(sB);
            2'b01:   return op[2] ? XLEN'(lane[15:0]) : XLEN'(sH);
            2'b10:   return op[2] ? XLEN'(lane[31:0]) : XLEN'(sW);
            default: return lane;
        endcase
    endfunction

    assign unusedAddr = ^req_addr[XLEN-1:AW+OFFW];

    always_comb begin
        reqSize    = req_optype[1:0];
        reqOff     = alignOff(req_optype[1:0], req_addr[OFFW-1:0]);
        reqIllegal = (req_read & req_write) || (req_optype == 3'b111)
                  || (XLEN == 32 && (req_optype == 3'b011 || req_optype == 3'b110));
`ifdef LSU_MISALIGN_CHECK_EN
        reqIllegal = reqIllegal || isMisaligned(reqSize, req_addr[OFFW-1:0]);
`endif
        accept     = req_valid & req_ready & (req_read | req_write);
        loadGo     = accept & ~reqIllegal & req_read;
    end

    // Stage boundary: accepted op becomes the registered RAM access / err pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_en <= accept & ~reqIllegal;
            mem_we <= (accept & ~reqIllegal & req_write) ? laneMask(reqSize, reqOff) : '0;
            err    <= accept & reqIllegal;
            if (accept & ~reqIllegal) begin
                mem_addr  <= req_addr[AW+OFFW-1:OFFW];
                mem_wdata <= replicateData(reqSize, req_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (loadGo) begin
            loadOp  <= req_optype;
            loadOff <= reqOff;
            loadRd  <= req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            latCnt <= '0;
        end else begin
            state  <= stateNext;
            latCnt <= (state == WAIT) ? latCnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (loadGo) stateNext = WAIT;
            WAIT:    if (latCnt == 3'(MEM_LAT - 1)) stateNext = WB;
            WB:      stateNext = loadGo ? WAIT : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Read data arrives in the WB cycle itself, so write-back data is extracted combinationally.
    always_comb begin
        req_ready = rstn && (state != WAIT);
        wb_dv     = rstn && (state == WB) && (loadRd != '0);
        wb_addr   = wb_dv ? loadRd : '0;
        wb_data   = wb_dv ? extendLoad(mem_rdata, loadOp, loadOff) : '0;
    end
endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: byte-level memory reference model, latency-accurate RAM model.
module tb_lsu_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;
    localparam int RSW   = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic            req_valid, req_ready, req_read, req_write;
    logic [31:0]     req_addr, req_data;
    logic [2:0]      req_optype;
    logic [RSW-1:0]  req_rd;
    logic            mem_en;
    logic [3:0]      mem_we;
    logic [9:0]      mem_addr;
    logic [31:0]     mem_wdata, mem_rdata;
    logic            wb_dv;
    logic [RSW-1:0]  wb_addr;
    logic [31:0]     wb_data;
    logic            err;

    lsu_unit #(.XLEN(XLEN), .RAM_DEPTH(DEPTH), .MEM_LAT(LAT), .REG_SEL_W(RSW)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .req_optype(req_optype), .req_rd(req_rd), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_dv(wb_dv),
        .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: address sampled at an edge, data visible LAT edges later; junk otherwise.
    logic [31:0] ramArr [DEPTH] = '{default: '0};
    logic [31:0] rdPipe [LAT]   = '{default: '0};
    always @(posedge clk) begin
        if (mem_en)
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) ramArr[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        for (int i = LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
        rdPipe[0] <= (mem_en && mem_we == 4'b0) ? ramArr[mem_addr] : $urandom;
    end
    assign mem_rdata = rdPipe[LAT-1];

    typedef struct {
        int          cyc;
        logic        isErr;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        chkData;
    } memEv;
    typedef struct {
        int             cyc;
        logic [RSW-1:0] rd;
        logic [31:0]    data;
    } wbEv;

    memEv       memQ[$];
    wbEv        wbQ[$];
    logic [7:0] refMem [DEPTH*4] = '{default: '0};
    int         lastLoadE = -100;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic bit modelReady(int c);
        return rstn && !(c >= lastLoadE && c < lastLoadE + LAT);
    endfunction

    // Reference: byte-addressed little-endian memory, accesses aligned to their size.
    task automatic modelOp(input logic rdOp, input logic wrOp, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] op,
                           input logic [RSW-1:0] rd, input int e);
        int size, off, aoff, word, base;
        logic illegal;
        logic [63:0] val;
        memEv m;
        wbEv w;
        if (!rdOp && !wrOp) return;
        size    = 1 << op[1:0];
        off     = int'(addr % 4);
        illegal = (rdOp && wrOp) || op == 3'b111 || op == 3'b011 || op == 3'b110;
`ifdef LSU_MISALIGN_CHECK_EN
        if (off % size != 0) illegal = 1'b1;
`endif
        aoff = off - (off % size);
        word = int'((addr / 4) % DEPTH);
        base = word * 4 + aoff;
        m.cyc = e; m.isErr = illegal; m.we = '0; m.addr = 10'(word); m.wdata = '0; m.chkData = 1'b0;
        if (!illegal && wrOp) begin
            for (int i = 0; i < size; i++) begin
                m.we[aoff + i]   = 1'b1;
                refMem[base + i] = data[8*i +: 8];
            end
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = data[8*(i % size) +: 8];
            m.chkData = 1'b1;
        end
        memQ.push_back(m);
        if (!illegal && rdOp) begin
            lastLoadE = e;
            if (rd != '0) begin
                val = '0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = refMem[base + i];
                if (!op[2] && val[8*size - 1]) val = val | ~((64'd1 << (8*size)) - 64'd1);
                w.cyc = e + LAT; w.rd = rd; w.data = val[31:0];
                wbQ.push_back(w);
            end
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge of the accept cycle.
    task automatic issue(input logic rdOp, input logic wrOp, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] op, input logic [RSW-1:0] rd);
        req_valid = 1'b1; req_read = rdOp; req_write = wrOp; req_addr = addr;
        req_data = data; req_optype = op; req_rd = rd;
        while (!modelReady(cyc)) begin
            @(negedge clk); #1;
        end
        modelOp(rdOp, wrOp, addr, data, op, rd, cyc + 1);
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycle %0d exceeds budget 50000", cyc);
            $fatal(1, "watchdog");
        end
        vectors++;
        if (!rstn) begin
            if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata, wb_dv, wb_addr, wb_data, err} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d: ready=%b en=%b we=%h addr=%h wdata=%h dv=%b wa=%0d wd=%h err=%b, required all 0",
                         cyc, req_ready, mem_en, mem_we, mem_addr, mem_wdata, wb_dv, wb_addr, wb_data, err);
            end
        end else begin
            if (req_ready !== modelReady(cyc)) begin
                miscompares++;
                $display("FAIL req_ready cyc=%0d: got %b, required %b", cyc, req_ready, modelReady(cyc));
            end
            while (memQ.size() > 0 && memQ[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL mem_missing: access due cyc=%0d absent (now %0d)", memQ[0].cyc, cyc);
                void'(memQ.pop_front());
            end
            while (wbQ.size() > 0 && wbQ[0].cyc < cyc) begin
                vectors++; miscompares++;
                $display("FAIL wb_missing: rd=%0d data=%h due cyc=%0d absent", wbQ[0].rd, wbQ[0].data, wbQ[0].cyc);
                void'(wbQ.pop_front());
            end
            if (mem_en || err || mem_we != 4'b0) begin
                vectors++;
                if (memQ.size() == 0 || memQ[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL mem_unexpected cyc=%0d: en=%b we=%h err=%b, required no activity", cyc, mem_en, mem_we, err);
                end else begin
                    memEv m;
                    m = memQ.pop_front();
                    if (m.isErr ? (mem_en !== 1'b0 || err !== 1'b1 || mem_we !== 4'b0)
                                : (mem_en !== 1'b1 || err !== 1'b0 || mem_we !== m.we || mem_addr !== m.addr
                                   || (m.chkData && mem_wdata !== m.wdata))) begin
                        miscompares++;
                        $display("FAIL mem_access cyc=%0d: en=%b err=%b we=%h addr=%0d wdata=%h, required en=%b err=%b we=%h addr=%0d wdata=%h",
                                 cyc, mem_en, err, mem_we, mem_addr, mem_wdata, !m.isErr, m.isErr, m.we, m.addr, m.wdata);
                    end
                end
            end
            if (wb_dv) begin
                vectors++;
                if (wbQ.size() == 0 || wbQ[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL wb_unexpected cyc=%0d: rd=%0d data=%h, required no write-back", cyc, wb_addr, wb_data);
                end else begin
                    wbEv w;
                    w = wbQ.pop_front();
                    if (wb_addr !== w.rd || wb_data !== w.data) begin
                        miscompares++;
                        $display("FAIL wb_data cyc=%0d: rd=%0d data=%h, required rd=%0d data=%h", cyc, wb_addr, wb_data, w.rd, w.data);
                    end
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_data = '0; req_optype = '0; req_rd = '0;
        idle(3);
        rstn = 1'b1;
        idle(1);
        // Stores and sign/zero-extended byte loads
        issue(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
        issue(0, 1, 32'h13, 32'h0000005A, 3'b000, 0);
        issue(1, 0, 32'h13, 32'h0, 3'b000, 5'd1);
        issue(1, 0, 32'h13, 32'h0, 3'b100, 5'd2);
        issue(0, 1, 32'h13, 32'h000000A5, 3'b000, 0);
        issue(1, 0, 32'h13, 32'h0, 3'b000, 5'd3);
        issue(1, 0, 32'h13, 32'h0, 3'b100, 5'd4);
        issue(0, 1, 32'h42, 32'h0000BEEF, 3'b001, 0);
        issue(1, 0, 32'h42, 32'h0, 3'b001, 5'd5);
        issue(1, 0, 32'h42, 32'h0, 3'b101, 5'd6);
        // Latency and back-to-back loads
        issue(0, 1, 32'h40, 32'h80001234, 3'b010, 0);
        idle(4);
        issue(1, 0, 32'h40, 32'h0, 3'b010, 5'd7);
        issue(1, 0, 32'h40, 32'h0, 3'b010, 5'd8);
        issue(1, 0, 32'h10, 32'h0, 3'b010, 5'd9);
        // Misaligned and illegal ops
        issue(0, 1, 32'h20, 32'hCAFEF00D, 3'b010, 0);
        issue(1, 0, 32'h21, 32'h0, 3'b001, 5'd10);
        issue(1, 0, 32'h23, 32'h0, 3'b010, 5'd11);
        issue(1, 1, 32'h20, 32'h0, 3'b010, 5'd12);
        issue(1, 0, 32'h20, 32'h0, 3'b111, 5'd13);
        issue(1, 0, 32'h20, 32'h0, 3'b011, 5'd14);
        issue(1, 0, 32'h20, 32'h0, 3'b110, 5'd15);
        issue(0, 1, 32'h20, 32'h5, 3'b011, 0);
        // rd=0 load, address wrap, no-op
        issue(1, 0, 32'h40, 32'h0, 3'b010, 5'd0);
        issue(0, 1, 32'h1004, 32'h12345678, 3'b010, 0);
        issue(1, 0, 32'h4, 32'h0, 3'b010, 5'd16);
        issue(0, 0, 32'h8, 32'h0, 3'b000, 5'd17);
        idle(LAT + 2);
        // Reset while a load waits on the RAM
        issue(1, 0, 32'h40, 32'h0, 3'b010, 5'd18);
        idle(1);
        rstn = 1'b0;
        wbQ.delete();
        lastLoadE = -100;
        idle(2);
        rstn = 1'b1;
        idle(1);
        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [2:0]  op;
            int          kind;
            a    = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            kind = $urandom_range(0, 99);
            if (kind < 45) begin
                op = (($urandom_range(0, 9)) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
                if (op == 3'b011 && $urandom_range(0, 1) == 1) op = 3'b010;
                issue(1, 0, a, 32'h0, op, 5'($urandom_range(0, 31)));
            end else if (kind < 90) begin
                op = (($urandom_range(0, 9)) == 0) ? 3'b111 : 3'($urandom_range(0, 2));
                issue(0, 1, a, $urandom, op, 5'($urandom_range(0, 31)));
            end else if (kind < 95) begin
                issue(1, 1, a, $urandom, 3'($urandom_range(0, 2)), 5'($urandom_range(1, 31)));
            end else begin
                issue(0, 0, a, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 4);
        vectors += memQ.size() + wbQ.size();
        foreach (memQ[i]) begin
            miscompares++;
            $display("FAIL mem_leftover: access due cyc=%0d never seen", memQ[i].cyc);
        end
        foreach (wbQ[i]) begin
            miscompares++;
            $display("FAIL wb_leftover: rd=%0d data=%h due cyc=%0d never seen", wbQ[i].rd, wbQ[i].data, wbQ[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
